// File: rtl/apb_cmd_master_if.sv
// Requester command/response channel plus the APB bus driven by apb_cmd_master.
// The master modport is the APB master side; slave is the requester/peripheral side.
interface apb_cmd_master_if #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [addrWidth-1:0] cmd_addr;
    logic [dataWidth-1:0] cmd_wdata;
    logic                 rsp_valid;
    logic [dataWidth-1:0] rsp_rdata;
    logic                 rsp_err;
    logic                 rsp_timeout;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [addrWidth-1:0] paddr;
    logic [dataWidth-1:0] pwdata;
    logic [dataWidth-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_cmd_master.sv
// Single-command APB master: IDLE -> SETUP -> ACCESS with wait states and
// an optional ACCESS timeout; every output comes straight from a flop.
module apb_cmd_master #(
    parameter int addrWidth     = 32,
    parameter int dataWidth     = 8,
    parameter int timeoutCycles = 16
) (
    input  logic             clk,
    input  logic             reset,
    apb_cmd_master_if.master bus
);
    localparam int  CntW      = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
    localparam bit  TimeoutOn = (timeoutCycles != 0);
    localparam logic [CntW-1:0] CntLast =
        CntW'((timeoutCycles > 0) ? timeoutCycles - 1 : 0);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [addrWidth-1:0] paddr_q, paddr_d;
    logic [dataWidth-1:0] pwdata_q, pwdata_d;
    logic                 rvalid_q, rvalid_d;
    logic [dataWidth-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 to_q, to_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ready_q   <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            to_q      <= to_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ready_d   = ready_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        to_d      = to_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d  = SETUP;
                    ready_d  = 1'b0;
                    psel_d   = 1'b1;
                    pwrite_d = bus.cmd_write;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                // pready on the timeout edge still completes normally
                if (bus.pready) begin
                    state_d   = IDLE;
                    ready_d   = 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = pwrite_q ? '0 : bus.prdata;
                    err_d     = bus.pslverr;
                    to_d      = 1'b0;
                end else if (TimeoutOn && cnt_q == CntLast) begin
                    state_d   = IDLE;
                    ready_d   = 1'b1;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = '0;
                    err_d     = 1'b1;
                    to_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready   = ready_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rvalid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = err_q;
    assign bus.rsp_timeout = to_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: timeline reference model, directed cases with
// literal latencies, randomized traffic, back-to-back and mid-transfer reset.
module tb_apb_cmd_master;
    localparam int AW = 32;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    apb_cmd_master_if #(.addrWidth(AW), .dataWidth(DW)) bus ();

    apb_cmd_master #(
        .addrWidth(AW), .dataWidth(DW), .timeoutCycles(TO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: the active command is described by its accept cycle
    // and its planned wait count; everything else is arithmetic on cycles
    bit            m_act = 1'b0;
    int            m_n   = 0;
    int            m_w   = 0;
    bit            m_wr  = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    bit            m_rv    = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_err   = 1'b0;
    bit            m_to    = 1'b0;

    int obs_rsp = -1;
    int obs_pen = 0;
    int accepts[$];

    bit            s_valid  = 1'b0;
    bit            s_wr     = 1'b0;
    logic [AW-1:0] s_addr   = '0;
    logic [DW-1:0] s_wdata  = '0;
    logic [DW-1:0] s_prdata = '0;
    bit            s_err    = 1'b0;
    int            s_w      = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic cycle_step();
        bit setup;
        bit access;
        int k;
        @(negedge clk);
        setup  = m_act && (cyc == m_n + 1);
        access = m_act && (cyc >= m_n + 2);
        k      = cyc - m_n - 2;
        chk("cmd_ready", 64'(bus.cmd_ready), 64'(!(setup || access)));
        chk("psel", 64'(bus.psel), 64'(setup || access));
        chk("penable", 64'(bus.penable), 64'(access));
        if (setup || access) begin
            chk("pwrite", 64'(bus.pwrite), 64'(m_wr));
            chk("paddr", 64'(bus.paddr), 64'(m_addr));
            chk("pwdata", 64'(bus.pwdata), 64'(m_wr ? m_wdata : '0));
        end
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rv));
        chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(m_rdata));
        chk("rsp_err", 64'(bus.rsp_err), 64'(m_err));
        chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(m_to));
        if (bus.rsp_valid) obs_rsp = cyc;
        if (bus.penable) obs_pen++;

        bus.cmd_valid = s_valid;
        bus.cmd_write = s_wr;
        bus.cmd_addr  = s_addr;
        bus.cmd_wdata = s_wdata;
        bus.prdata    = s_prdata;
        bus.pslverr   = s_err;
        bus.pready    = access ? (k == m_w) : 1'($urandom_range(0, 1));

        m_rv = 1'b0;
        if (access && k == m_w) begin
            m_act   = 1'b0;
            m_rv    = 1'b1;
            m_rdata = m_wr ? '0 : s_prdata;
            m_err   = s_err;
            m_to    = 1'b0;
        end else if (access && TO != 0 && k == TO - 1) begin
            m_act   = 1'b0;
            m_rv    = 1'b1;
            m_rdata = '0;
            m_err   = 1'b1;
            m_to    = 1'b1;
        end else if (!setup && !access && s_valid) begin
            m_act   = 1'b1;
            m_n     = cyc;
            m_w     = s_w;
            m_wr    = s_wr;
            m_addr  = s_addr;
            m_wdata = s_wdata;
            obs_pen = 0;
            accepts.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic txn(input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int w,
                       input logic [DW-1:0] rd, input bit e,
                       input int exp_lat, input int exp_pen,
                       input logic [DW-1:0] exp_rd, input bit exp_err,
                       input bit exp_to);
        int n0;
        s_valid = 1'b1; s_wr = wr; s_addr = a; s_wdata = d;
        s_w = w; s_prdata = rd; s_err = e;
        for (int i = 0; i < 40 && !m_act; i++) cycle_step();
        s_valid = 1'b0;
        s_wdata = ~d;
        s_addr  = ~a;
        n0      = m_n;
        obs_rsp = -1;
        for (int i = 0; i < 40 && obs_rsp < 0; i++) cycle_step();
        chk("latency", 64'(obs_rsp - n0), 64'(exp_lat));
        chk("penable_cycles", 64'(obs_pen), 64'(exp_pen));
        chk("lit_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
        chk("lit_err", 64'(bus.rsp_err), 64'(exp_err));
        chk("lit_timeout", 64'(bus.rsp_timeout), 64'(exp_to));
        cycle_step();
    endtask

    initial begin
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0;
        bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("rst_psel", 64'(bus.psel), 64'd0);
        chk("rst_penable", 64'(bus.penable), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_paddr", 64'(bus.paddr), 64'd0);
        reset = 1'b0;
        cycle_step();

        // write addr 1 data 25, no wait
        txn(1'b1, 32'd1, 8'd25, 0, 8'h00, 1'b0, 3, 1, 8'h00, 1'b0, 1'b0);
        // read, 3 wait states returning A5
        txn(1'b0, 32'd2, 8'd7, 3, 8'hA5, 1'b0, 6, 4, 8'hA5, 1'b0, 1'b0);
        // slave never ready: timeout
        txn(1'b0, 32'h40, 8'd0, 100, 8'h3C, 1'b0, 18, 16, 8'h00, 1'b1, 1'b1);
        // pready on the would-be timeout edge
        txn(1'b0, 32'h44, 8'd0, 15, 8'h5A, 1'b0, 18, 16, 8'h5A, 1'b0, 1'b0);
        // exactly one wait too many
        txn(1'b1, 32'h48, 8'h11, 16, 8'h77, 1'b0, 18, 16, 8'h00, 1'b1, 1'b1);
        // slave error on a read
        txn(1'b0, 32'h4C, 8'd0, 0, 8'h66, 1'b1, 3, 1, 8'h66, 1'b1, 1'b0);

        // back-to-back with cmd_valid held high
        accepts.delete();
        s_valid = 1'b1; s_w = 0; s_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_wr = 1'($urandom()); s_addr = $urandom();
            s_wdata = 8'($urandom()); s_prdata = 8'($urandom());
            cycle_step();
        end
        s_valid = 1'b0;
        repeat (3) cycle_step();
        chk("b2b_count", 64'(accepts.size()), 64'd3);
        if (accepts.size() >= 3) begin
            chk("b2b_gap1", 64'(accepts[1] - accepts[0]), 64'd3);
            chk("b2b_gap2", 64'(accepts[2] - accepts[1]), 64'd3);
        end

        // reset asserted in the middle of ACCESS
        s_valid = 1'b1; s_wr = 1'b0; s_addr = 32'h80; s_w = 10;
        for (int i = 0; i < 20 && !(m_act && cyc >= m_n + 4); i++)
            cycle_step();
        s_valid = 1'b0;
        chk("pre_rst_penable", 64'(bus.penable), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_psel", 64'(bus.psel), 64'd0);
        chk("async_penable", 64'(bus.penable), 64'd0);
        chk("async_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("async_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        m_act = 1'b0; m_rv = 1'b0; m_rdata = '0; m_err = 1'b0; m_to = 1'b0;
        repeat (2) cycle_step();
        reset = 1'b0;
        obs_rsp = -1;
        repeat (12) cycle_step();
        chk("no_rsp_after_abort", 64'(obs_rsp), 64'hFFFF_FFFF_FFFF_FFFF);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            s_valid  = ($urandom_range(0, 2) != 0);
            s_wr     = 1'($urandom());
            s_addr   = $urandom();
            s_wdata  = 8'($urandom());
            s_prdata = 8'($urandom());
            s_err    = ($urandom_range(0, 4) == 0);
            r = $urandom_range(0, 9);
            if (r < 5)      s_w = $urandom_range(0, 3);
            else if (r < 8) s_w = $urandom_range(4, 12);
            else            s_w = $urandom_range(13, 20);
            cycle_step();
        end
        s_valid = 1'b0;
        repeat (25) cycle_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
